// File: rtl/sevseg_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_scan_sequencer
//  Description : Deterministic scan sequencer for an 8-digit multiplexed
//                seven-segment display. Each digit slot has a blank dead-time
//                sub-slot, 4-bit PWM brightness and leading-zero suppression.
//                Display inputs are shadowed once per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module sevseg_scan_sequencer #(
    parameter int SUB_CYCLES = 390,
    parameter int SUB_W      = $clog2(SUB_CYCLES + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [31:0] i_digits,
    input  logic [7:0]  i_enables,
    input  logic [7:0]  i_dp,
    input  logic [3:0]  i_bright,
    input  logic        i_lz_en,
    output logic [7:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_frame_start
);

    // Scan position: cycle within sub-slot, sub-slot within digit, digit.
    logic [SUB_W-1:0] sub_cnt;
    logic [3:0]       sub_idx;
    logic [2:0]       dig_idx;

    // Frame-atomic copies of the display registers. The leading-zero enable
    // is folded directly into lz_mask when the frame starts.
    logic [31:0] sh_digits;
    logic [7:0]  sh_enables;
    logic [7:0]  sh_dp;
    logic [3:0]  sh_bright;
    logic [7:0]  lz_mask;

    logic       sub_last;
    logic       frame_start_now;
    logic       lit;
    logic [3:0] cur_digit;

    // Hex digit to active-low segments, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] hex);
        case (hex)
            4'h0:    seg_decode = 7'b0000001;
            4'h1:    seg_decode = 7'b1001111;
            4'h2:    seg_decode = 7'b0010010;
            4'h3:    seg_decode = 7'b0000110;
            4'h4:    seg_decode = 7'b1001100;
            4'h5:    seg_decode = 7'b0100100;
            4'h6:    seg_decode = 7'b0100000;
            4'h7:    seg_decode = 7'b0001111;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0001100;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b1100000;
            4'hC:    seg_decode = 7'b1110010;
            4'hD:    seg_decode = 7'b1000010;
            4'hE:    seg_decode = 7'b0110000;
            default: seg_decode = 7'b0111000;
        endcase
    endfunction

    // Visible-digit mask: walking down from digit 7, a digit stays blank
    // until a non-zero digit has been seen; digit 0 is always visible.
    function automatic logic [7:0] lz_visible(input logic [31:0] d, input logic lz_en);
        logic       seen;
        logic [7:0] vis;
        seen = 1'b0;
        vis  = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            seen   = seen | (d[4*k +: 4] != 4'h0);
            vis[k] = !lz_en || seen || (k == 0);
        end
        return vis;
    endfunction

    // Scan position decode and lit qualification for the current cycle.
    always_comb begin
        sub_last        = (sub_cnt == SUB_W'(SUB_CYCLES - 1));
        frame_start_now = i_en && (sub_cnt == '0) && (sub_idx == 4'd0) && (dig_idx == 3'd0);
        cur_digit       = sh_digits[{dig_idx, 2'b00} +: 4];
        lit             = (sub_idx != 4'd0) && (sub_idx <= sh_bright)
                          && sh_enables[dig_idx] && lz_mask[dig_idx];
    end

    // Counters, frame shadowing and registered pin outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sub_cnt       <= '0;
            sub_idx       <= 4'd0;
            dig_idx       <= 3'd0;
            sh_digits     <= 32'h0;
            sh_enables    <= 8'h00;
            sh_dp         <= 8'h00;
            sh_bright     <= 4'd0;
            lz_mask       <= 8'h00;
            o_an          <= 8'hFF;
            o_seg         <= 7'h7F;
            o_dp          <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= frame_start_now;
            if (!i_en) begin
                sub_cnt <= '0;
                sub_idx <= 4'd0;
                dig_idx <= 3'd0;
                o_an    <= 8'hFF;
                o_seg   <= 7'h7F;
                o_dp    <= 1'b1;
            end else begin
                if (frame_start_now) begin
                    sh_digits  <= i_digits;
                    sh_enables <= i_enables;
                    sh_dp      <= i_dp;
                    sh_bright  <= i_bright;
                    lz_mask    <= lz_visible(i_digits, i_lz_en);
                end
                if (lit) begin
                    o_an  <= ~(8'b1 << dig_idx);
                    o_seg <= seg_decode(cur_digit);
                    o_dp  <= ~sh_dp[dig_idx];
                end else begin
                    o_an  <= 8'hFF;
                    o_seg <= 7'h7F;
                    o_dp  <= 1'b1;
                end
                if (sub_last) begin
                    sub_cnt <= '0;
                    sub_idx <= sub_idx + 4'd1;
                    if (sub_idx == 4'hF) begin
                        dig_idx <= dig_idx + 3'd1;
                    end
                end else begin
                    sub_cnt <= sub_cnt + SUB_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sevseg_scan_sequencer
//  Description : Scoreboard bench for sevseg_scan_sequencer (SUB_CYCLES=2).
//                A frame-position reference model predicts every output cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sevseg_scan_sequencer;

    localparam int SUB   = 2;
    localparam int SLOT  = 16 * SUB;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n, en, lz_en;
    logic [31:0] digits;
    logic [7:0]  enables, dpin;
    logic [3:0]  bright;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp, fs;

    sevseg_scan_sequencer #(.SUB_CYCLES(SUB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_digits(digits),
        .i_enables(enables), .i_dp(dpin), .i_bright(bright), .i_lz_en(lz_en),
        .o_an(an), .o_seg(seg), .o_dp(dp), .o_frame_start(fs)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [16:0] sb[$];
    logic [16:0] exp_out, got_out;
    logic [6:0]  dec [0:15];

    int          m_pos = 0;
    logic [31:0] m_dig = '0;
    logic [7:0]  m_en = '0, m_dp = '0, m_vis = '0;
    logic [3:0]  m_bright = '0;

    // Reference model: predicts the outputs after the coming edge.
    task automatic predict();
        logic [16:0] e;
        int d, s;
        e = {8'hFF, 7'h7F, 1'b1, 1'b0};
        if (!rst_n) begin
            m_pos = 0; m_dig = '0; m_en = '0; m_dp = '0; m_vis = '0; m_bright = '0;
        end else if (!en) begin
            m_pos = 0;
        end else begin
            if (m_pos == 0) begin
                m_dig = digits; m_en = enables; m_dp = dpin; m_bright = bright;
                for (int k = 0; k < 8; k++)
                    m_vis[k] = !lz_en || (k == 0) || ((digits >> (4 * k)) != 32'h0);
            end
            d = m_pos / SLOT;
            s = (m_pos % SLOT) / SUB;
            if (s != 0 && s <= int'(m_bright) && m_en[d] && m_vis[d])
                e = {~(8'h01 << d), dec[m_dig[4*d +: 4]], ~m_dp[d], 1'b0};
            e[0] = (m_pos == 0);
            m_pos = (m_pos + 1) % FRAME;
        end
        sb.push_back(e);
    endtask

    task automatic cycle();
        predict();
        @(posedge clk);
        #1;
        cyc++;
        exp_out = sb.pop_front();
        got_out = {an, seg, dp, fs};
    endtask

    task automatic test_reset();
        int fs_cnt, fs_idx;
        rst_n = 1'b0; en = 1'b1; digits = 32'h76543210; enables = 8'hFF;
        dpin = 8'h05; bright = 4'd15; lz_en = 1'b0;
        repeat (2) begin
            cycle();
            n_checks++;
            if ({an, seg, dp, fs} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_blank cyc %0d got %h exp %h", cyc, got_out, 17'h1FFFE);
            end
        end
        rst_n = 1'b1;
        fs_cnt = 0; fs_idx = -1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_checks++;
            if (got_out !== exp_out) begin
                n_fail++;
                $display("FAIL reset_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
            if (fs) begin fs_cnt++; if (fs_idx < 0) fs_idx = i; end
        end
        n_checks++;
        if (fs_cnt != 1 || fs_idx != 0) begin
            n_fail++;
            $display("FAIL reset_frame_pulse got count %0d at %0d exp count 1 at 0", fs_cnt, fs_idx);
        end
    endtask

    task automatic test_full_bright();
        int lit_cnt, multi, first_fs, period;
        lit_cnt = 0; multi = 0; first_fs = -1; period = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            n_checks++;
            if (got_out !== exp_out) begin
                n_fail++;
                $display("FAIL full_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
            if (an != 8'hFF) lit_cnt++;
            if ($countones(~an) > 1) multi++;
            if (fs) begin
                if (first_fs < 0) first_fs = i;
                else if (period < 0) period = i - first_fs;
            end
        end
        n_checks++;
        if (lit_cnt != 2 * 8 * 30) begin
            n_fail++;
            $display("FAIL full_lit_count got %0d exp %0d", lit_cnt, 2 * 8 * 30);
        end
        n_checks++;
        if (multi != 0) begin
            n_fail++;
            $display("FAIL one_hot_anode got %0d cycles exp 0", multi);
        end
        n_checks++;
        if (period != FRAME) begin
            n_fail++;
            $display("FAIL frame_period got %0d exp %0d", period, FRAME);
        end
    endtask

    task automatic test_brightness();
        logic [3:0] br_tab [2];
        int         exp_tab [2];
        int         lit_cnt;
        bit         found;
        br_tab  = '{4'd4, 4'd0};
        exp_tab = '{8 * 4 * SUB, 0};
        for (int t = 0; t < 2; t++) begin
            bright = br_tab[t];
            found = 0;
            for (int i = 0; i < FRAME + 8 && !found; i++) begin
                cycle();
                n_checks++;
                if (got_out !== exp_out) begin
                    n_fail++;
                    $display("FAIL bright_sync_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
                end
                if (exp_out[0]) found = 1;
            end
            n_checks++;
            if (!found) begin n_fail++; $display("FAIL bright_sync timeout got none exp frame start"); end
            lit_cnt = 0;
            for (int i = 0; i < FRAME; i++) begin
                cycle();
                n_checks++;
                if (got_out !== exp_out) begin
                    n_fail++;
                    $display("FAIL bright_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
                end
                if (an != 8'hFF) lit_cnt++;
            end
            n_checks++;
            if (lit_cnt != exp_tab[t]) begin
                n_fail++;
                $display("FAIL bright_%0d_lit got %0d exp %0d", br_tab[t], lit_cnt, exp_tab[t]);
            end
        end
    endtask

    task automatic test_lz_suppress();
        logic [31:0] dg_tab [2];
        int          exp_tab [2];
        logic [7:0]  ok_tab [2];
        int          lit_cnt, bad;
        bit          found;
        dg_tab  = '{32'h00000120, 32'h00000000};
        exp_tab = '{3 * 30, 30};
        ok_tab  = '{8'h07, 8'h01};
        bright = 4'd15; lz_en = 1'b1;
        for (int t = 0; t < 2; t++) begin
            digits = dg_tab[t];
            found = 0;
            for (int i = 0; i < FRAME + 8 && !found; i++) begin
                cycle();
                n_checks++;
                if (got_out !== exp_out) begin
                    n_fail++;
                    $display("FAIL lz_sync_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
                end
                if (exp_out[0]) found = 1;
            end
            n_checks++;
            if (!found) begin n_fail++; $display("FAIL lz_sync timeout got none exp frame start"); end
            lit_cnt = 0; bad = 0;
            for (int i = 0; i < FRAME; i++) begin
                cycle();
                n_checks++;
                if (got_out !== exp_out) begin
                    n_fail++;
                    $display("FAIL lz_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
                end
                if (an != 8'hFF) lit_cnt++;
                if ((~an & ~ok_tab[t]) != 8'h00) bad++;
            end
            n_checks++;
            if (lit_cnt != exp_tab[t] || bad != 0) begin
                n_fail++;
                $display("FAIL lz_%0d_pattern got lit %0d bad %0d exp lit %0d bad 0", t, lit_cnt, bad, exp_tab[t]);
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_shadow();
        int  old_d5, new_d5;
        bit  found;
        digits = 32'h76543210; enables = 8'hFF; dpin = 8'h00;
        found = 0;
        for (int i = 0; i < FRAME + 8 && !found; i++) begin
            cycle();
            n_checks++;
            if (got_out !== exp_out) begin
                n_fail++;
                $display("FAIL shadow_sync_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
            if (exp_out[0]) found = 1;
        end
        repeat (100) begin
            cycle();
            n_checks++;
            if (got_out !== exp_out) begin
                n_fail++;
                $display("FAIL shadow_pre_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
        end
        digits = 32'h89ABCDEF; enables = 8'h0F; dpin = 8'hFF;
        old_d5 = 0; found = 0;
        for (int i = 0; i < FRAME && !found; i++) begin
            cycle();
            n_checks++;
            if (got_out !== exp_out) begin
                n_fail++;
                $display("FAIL shadow_hold_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
            if (an == 8'hDF) old_d5++;
            if (exp_out[0]) found = 1;
        end
        new_d5 = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            n_checks++;
            if (got_out !== exp_out) begin
                n_fail++;
                $display("FAIL shadow_new_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
            if (an == 8'hDF) new_d5++;
        end
        n_checks++;
        if (old_d5 != 30 || new_d5 != 0) begin
            n_fail++;
            $display("FAIL shadow_digit5 got old %0d new %0d exp old 30 new 0", old_d5, new_d5);
        end
    endtask

    task automatic test_en_drop();
        digits = 32'h76543210; enables = 8'hFF; bright = 4'd15;
        repeat (40) begin
            cycle();
            n_checks++;
            if (got_out !== exp_out) begin
                n_fail++;
                $display("FAIL endrop_pre_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++;
            if (an !== 8'hFF || fs !== 1'b0 || got_out !== exp_out) begin
                n_fail++;
                $display("FAIL endrop_blank cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (got_out !== exp_out) begin
                n_fail++;
                $display("FAIL reenable_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
            n_checks++;
            if ((i == 0 && fs !== 1'b1) || (i == 2 && an !== 8'hFE)) begin
                n_fail++;
                $display("FAIL reenable_step%0d got fs %b an %h exp fs 1 then an fe", i, fs, an);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (50) cycle();
        rst_n = 1'b0;
        cycle();
        n_checks++;
        if (got_out !== {8'hFF, 7'h7F, 1'b1, 1'b0} || got_out !== exp_out) begin
            n_fail++;
            $display("FAIL midreset_blank got %h exp %h", got_out, exp_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_checks++;
            if (got_out !== exp_out || (i == 0 && fs !== 1'b1)) begin
                n_fail++;
                $display("FAIL midreset_sb cyc %0d got %h exp %h", cyc, got_out, exp_out);
            end
        end
    endtask

    initial begin
        dec = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};
        test_reset();
        test_full_bright();
        test_brightness();
        test_lz_suppress();
        test_shadow();
        test_en_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
